// File: rtl/dma_csr_if.sv
// AXI4-Lite slave bus bundle for the dma_csr register block.
// The master drives address/data/ready-for-response; the slave answers.
interface dma_csr_if #(
    parameter int ADDR_W = 5
) ();
    logic [ADDR_W-1:0] S_AWADDR;
    logic              S_AWVALID;
    logic              S_AWREADY;
    logic [31:0]       S_WDATA;
    logic [3:0]        S_WSTRB;
    logic              S_WVALID;
    logic              S_WREADY;
    logic [1:0]        S_BRESP;
    logic              S_BVALID;
    logic              S_BREADY;
    logic [ADDR_W-1:0] S_ARADDR;
    logic              S_ARVALID;
    logic              S_ARREADY;
    logic [31:0]       S_RDATA;
    logic [1:0]        S_RRESP;
    logic              S_RVALID;
    logic              S_RREADY;

    modport master (
        output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID,
        output S_BREADY, S_ARADDR, S_ARVALID, S_RREADY,
        input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
        input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );

    modport slave (
        input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID,
        input  S_BREADY, S_ARADDR, S_ARVALID, S_RREADY,
        output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
        output S_ARREADY, S_RDATA, S_RRESP, S_RVALID
    );
endinterface

// File: rtl/dma_csr.sv
// AXI4-Lite control/status registers in front of the dma engine:
// holds SRC/DST/LEN, fires trigger on START, tracks BUSY and sticky DONE.
module dma_csr (
    input  logic        clk,
    input  logic        rst,
    dma_csr_if.slave    s,
    output logic        trigger,
    output logic [4:0]  length,
    output logic [31:0] source_address,
    output logic [31:0] destination_address,
    input  logic        done,
    output logic        irq
);
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    wstate_t     wstate;
    rstate_t     rstate;
    logic        aw_held, w_held;
    logic [2:0]  aw_idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        busy, done_q, irq_en;
    logic        bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic        aw_fire, w_fire, wr_go;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_err, start_ok;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        unused_addr_lo;

    assign unused_addr_lo = ^{s.S_AWADDR[1:0], s.S_ARADDR[1:0]};

    assign s.S_AWREADY = (wstate == W_IDLE) && !aw_held;
    assign s.S_WREADY  = (wstate == W_IDLE) && !w_held;
    assign s.S_ARREADY = (rstate == R_IDLE);
    assign s.S_BVALID  = bvalid;
    assign s.S_BRESP   = bresp;
    assign s.S_RVALID  = rvalid;
    assign s.S_RDATA   = rdata;
    assign s.S_RRESP   = rresp;
    assign irq         = done_q & irq_en;

    assign aw_fire = s.S_AWVALID && s.S_AWREADY;
    assign w_fire  = s.S_WVALID && s.S_WREADY;
    assign wr_idx  = aw_held ? aw_idx_q : s.S_AWADDR[4:2];
    assign wr_data = w_held ? wdata_q : s.S_WDATA;
    assign wr_strb = w_held ? wstrb_q : s.S_WSTRB;
    assign wr_go   = (wstate == W_IDLE) &&
                     (aw_held || aw_fire) && (w_held || w_fire);

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  st
    );
        merge = old;
        for (int i = 0; i < 4; i++)
            if (st[i]) merge[8*i +: 8] = d[8*i +: 8];
    endfunction

    // Transfer parameters are frozen while the engine is running.
    always_comb begin
        wr_err   = 1'b0;
        start_ok = 1'b0;
        case (wr_idx)
            3'd0: begin
                start_ok = wr_data[0] && !busy && (length != 5'd0);
                wr_err   = wr_data[0] && !start_ok;
            end
            3'd1:                 wr_err = 1'b0;
            3'd2, 3'd3, 3'd4:     wr_err = busy;
            default:              wr_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (s.S_ARADDR[4:2])
            3'd0:    rd_data = {30'd0, irq_en, 1'b0};
            3'd1:    rd_data = {30'd0, done_q, busy};
            3'd2:    rd_data = source_address;
            3'd3:    rd_data = destination_address;
            3'd4:    rd_data = {27'd0, length};
            default: rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wstate              <= W_IDLE;
            aw_held             <= 1'b0;
            w_held              <= 1'b0;
            aw_idx_q            <= '0;
            wdata_q             <= '0;
            wstrb_q             <= '0;
            bvalid              <= 1'b0;
            bresp               <= OKAY;
            trigger             <= 1'b0;
            busy                <= 1'b0;
            done_q              <= 1'b0;
            irq_en              <= 1'b0;
            length              <= '0;
            source_address      <= '0;
            destination_address <= '0;
        end else begin
            trigger <= 1'b0;
            if (aw_fire) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s.S_AWADDR[4:2];
            end
            if (w_fire) begin
                w_held  <= 1'b1;
                wdata_q <= s.S_WDATA;
                wstrb_q <= s.S_WSTRB;
            end
            unique case (wstate)
                W_IDLE: if (wr_go) begin
                    wstate <= W_RESP;
                    bvalid <= 1'b1;
                    bresp  <= wr_err ? SLVERR : OKAY;
                    if (!wr_err) begin
                        case (wr_idx)
                            3'd2: source_address <=
                                merge(source_address, wr_data, wr_strb);
                            3'd3: destination_address <=
                                merge(destination_address, wr_data, wr_strb);
                            3'd4: if (wr_strb[0]) length <= wr_data[4:0];
                            default: ;
                        endcase
                    end
                    if (wr_idx == 3'd0) begin
                        irq_en <= wr_data[1];
                        if (start_ok) begin
                            trigger <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    if (wr_idx == 3'd1 && wr_data[1]) done_q <= 1'b0;
                end
                W_RESP: if (s.S_BREADY) begin
                    wstate  <= W_IDLE;
                    bvalid  <= 1'b0;
                    bresp   <= OKAY;
                    aw_held <= 1'b0;
                    w_held  <= 1'b0;
                end
            endcase
            // A completion beats a simultaneous W1C of DONE.
            if (done && busy) begin
                busy   <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rstate <= R_IDLE;
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= OKAY;
        end else begin
            unique case (rstate)
                R_IDLE: if (s.S_ARVALID) begin
                    rstate <= R_DATA;
                    rvalid <= 1'b1;
                    rdata  <= rd_data;
                    rresp  <= rd_err ? SLVERR : OKAY;
                end
                R_DATA: if (s.S_RREADY) begin
                    rstate <= R_IDLE;
                    rvalid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dma_csr.sv
// Directed bench for dma_csr: programs a transfer, exercises error
// responses, split AW/W with stalled B, byte strobes and async reset.
module tb_dma_csr;
    logic        clk;
    logic        rst;
    logic        trigger;
    logic [4:0]  length;
    logic [31:0] source_address;
    logic [31:0] destination_address;
    logic        done;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;
    int trig_cnt = 0;

    logic [1:0]  resp;
    logic        trg;
    logic [31:0] rd;

    dma_csr_if #(.ADDR_W(5)) bus ();

    dma_csr dut (
        .clk                 (clk),
        .rst                 (rst),
        .s                   (bus),
        .trigger             (trigger),
        .length              (length),
        .source_address      (source_address),
        .destination_address (destination_address),
        .done                (done),
        .irq                 (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (trigger) trig_cnt++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_wr(input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] st, output logic [1:0] r,
                          output logic t);
        bit aw_ok, w_ok;
        int n;
        bus.S_AWADDR  = a;
        bus.S_WDATA   = d;
        bus.S_WSTRB   = st;
        bus.S_AWVALID = 1'b1;
        bus.S_WVALID  = 1'b1;
        bus.S_BREADY  = 1'b1;
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        n     = 0;
        while (!(aw_ok && w_ok) && n < 16) begin
            @(negedge clk);
            if (bus.S_AWVALID && bus.S_AWREADY) aw_ok = 1'b1;
            if (bus.S_WVALID && bus.S_WREADY) w_ok = 1'b1;
            @(posedge clk); #1;
            if (aw_ok) bus.S_AWVALID = 1'b0;
            if (w_ok) bus.S_WVALID = 1'b0;
            n++;
        end
        bus.S_AWVALID = 1'b0;
        bus.S_WVALID  = 1'b0;
        chk("wr_bvalid", {31'd0, bus.S_BVALID}, 32'd1);
        r = bus.S_BRESP;
        t = trigger;
        @(posedge clk); #1;
        bus.S_BREADY = 1'b0;
    endtask

    task automatic axi_rd(input logic [4:0] a, output logic [31:0] d,
                          output logic [1:0] r);
        bit ok;
        int n;
        bus.S_ARADDR  = a;
        bus.S_ARVALID = 1'b1;
        bus.S_RREADY  = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 16) begin
            @(negedge clk);
            ok = bus.S_ARREADY;
            @(posedge clk); #1;
            n++;
        end
        bus.S_ARVALID = 1'b0;
        chk("rd_rvalid", {31'd0, bus.S_RVALID}, 32'd1);
        d = bus.S_RDATA;
        r = bus.S_RRESP;
        @(posedge clk); #1;
        bus.S_RREADY = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        done = 1'b0;
        bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0;
        bus.S_WDATA = '0;  bus.S_WSTRB = '0; bus.S_WVALID = 1'b0;
        bus.S_BREADY = 1'b0;
        bus.S_ARADDR = '0; bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_awready", {31'd0, bus.S_AWREADY}, 32'd1);
        chk("rst_wready", {31'd0, bus.S_WREADY}, 32'd1);
        chk("rst_arready", {31'd0, bus.S_ARREADY}, 32'd1);
        chk("rst_bvalid", {31'd0, bus.S_BVALID}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.S_RVALID}, 32'd0);
        chk("rst_trigger", {31'd0, trigger}, 32'd0);
        chk("rst_src", source_address, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        axi_wr(5'h08, 32'h0000_1003, 4'hF, resp, trg);
        chk("src_resp", {30'd0, resp}, 32'd0);
        axi_wr(5'h0C, 32'h0000_2001, 4'hF, resp, trg);
        chk("dst_resp", {30'd0, resp}, 32'd0);
        axi_wr(5'h10, 32'd7, 4'hF, resp, trg);
        chk("len_resp", {30'd0, resp}, 32'd0);
        chk("len_no_trig", {31'd0, trg}, 32'd0);
        axi_wr(5'h00, 32'h3, 4'hF, resp, trg);
        chk("start_resp", {30'd0, resp}, 32'd0);
        chk("start_trig", {31'd0, trg}, 32'd1);
        chk("trig_after", {31'd0, trigger}, 32'd0);
        chk("trig_width", trig_cnt, 32'd1);
        chk("src_out", source_address, 32'h0000_1003);
        chk("dst_out", destination_address, 32'h0000_2001);
        chk("len_out", {27'd0, length}, 32'd7);
        axi_rd(5'h04, rd, resp);
        chk("status_busy", rd, 32'h1);
        axi_rd(5'h00, rd, resp);
        chk("ctrl_rd", rd, 32'h2);

        axi_wr(5'h08, 32'hFFFF_FFFF, 4'hF, resp, trg);
        chk("busy_src_resp", {30'd0, resp}, 32'd2);
        axi_wr(5'h10, 32'd3, 4'hF, resp, trg);
        chk("busy_len_resp", {30'd0, resp}, 32'd2);
        axi_wr(5'h00, 32'h3, 4'hF, resp, trg);
        chk("busy_start_resp", {30'd0, resp}, 32'd2);
        chk("busy_start_trig", {31'd0, trg}, 32'd0);
        chk("busy_src_kept", source_address, 32'h0000_1003);
        chk("busy_len_kept", {27'd0, length}, 32'd7);
        chk("busy_trig_cnt", trig_cnt, 32'd1);

        pulse_done();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        axi_rd(5'h04, rd, resp);
        chk("status_done", rd, 32'h2);
        axi_wr(5'h04, 32'h2, 4'hF, resp, trg);
        chk("w1c_resp", {30'd0, resp}, 32'd0);
        chk("irq_fall", {31'd0, irq}, 32'd0);
        axi_rd(5'h04, rd, resp);
        chk("status_clr", rd, 32'h0);

        pulse_done();
        axi_rd(5'h04, rd, resp);
        chk("idle_done_ign", rd, 32'h0);

        axi_wr(5'h10, 32'd0, 4'hF, resp, trg);
        axi_wr(5'h00, 32'h1, 4'hF, resp, trg);
        chk("len0_resp", {30'd0, resp}, 32'd2);
        chk("len0_trig", {31'd0, trg}, 32'd0);
        axi_rd(5'h04, rd, resp);
        chk("len0_status", rd, 32'h0);
        axi_rd(5'h00, rd, resp);
        chk("len0_irqen_upd", rd, 32'h0);

        bus.S_BREADY = 1'b0;
        bus.S_WDATA  = 32'hAABB_CCDD;
        bus.S_WSTRB  = 4'b0101;
        bus.S_WVALID = 1'b1;
        @(negedge clk);
        chk("early_wready", {31'd0, bus.S_WREADY}, 32'd1);
        @(posedge clk); #1;
        bus.S_WVALID = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("held_wready", {31'd0, bus.S_WREADY}, 32'd0);
        chk("held_awready", {31'd0, bus.S_AWREADY}, 32'd1);
        chk("held_bvalid", {31'd0, bus.S_BVALID}, 32'd0);
        bus.S_AWADDR  = 5'h08;
        bus.S_AWVALID = 1'b1;
        @(posedge clk); #1;
        bus.S_AWVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_bvalid", {31'd0, bus.S_BVALID}, 32'd1);
            chk("stall_bresp", {30'd0, bus.S_BRESP}, 32'd0);
            chk("stall_awready", {31'd0, bus.S_AWREADY}, 32'd0);
            if (i == 3) bus.S_BREADY = 1'b1;
            @(posedge clk); #1;
        end
        bus.S_BREADY = 1'b0;
        chk("stall_bdone", {31'd0, bus.S_BVALID}, 32'd0);
        chk("strb_src", source_address, 32'h00BB_10DD);

        axi_rd(5'h14, rd, resp);
        chk("bad_rd_data", rd, 32'h0);
        chk("bad_rd_resp", {30'd0, resp}, 32'd2);
        axi_wr(5'h18, 32'h1, 4'hF, resp, trg);
        chk("bad_wr_resp", {30'd0, resp}, 32'd2);

        axi_wr(5'h10, 32'd7, 4'hF, resp, trg);
        axi_wr(5'h00, 32'h3, 4'hF, resp, trg);
        chk("rstart_trig", {31'd0, trg}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_src", source_address, 32'h0);
        chk("arst_len", {27'd0, length}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        axi_rd(5'h04, rd, resp);
        chk("arst_status", rd, 32'h0);
        axi_rd(5'h00, rd, resp);
        chk("arst_ctrl", rd, 32'h0);
        axi_rd(5'h0C, rd, resp);
        chk("arst_dst", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dma_csr.md
# dma_csr

AXI4-Lite slave control/status register block sitting directly upstream of the `dma` top. It holds the source address, destination address and byte length programmed by the host CPU. On a START write it issues the single-cycle `trigger` pulse into `dma` and tracks busy state until `dma` returns `done`. It then latches a sticky DONE status and raises an optional level interrupt.

## Interface
- `ADDR_W`, 5: AXI4-Lite address width; register offsets 0x00–0x10.
- `clk`  input  1  clock, all logic on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `S_AWADDR`  input  ADDR_W  write address
- `S_AWVALID` / `S_AWREADY`  input / output  1  AW handshake
- `S_WDATA`  input  32  write data
- `S_WSTRB`  input  4  byte-lane strobes
- `S_WVALID` / `S_WREADY`  input / output  1  W handshake
- `S_BRESP`  output  2  2'b00 OKAY, 2'b10 SLVERR
- `S_BVALID` / `S_BREADY`  output / input  1  B handshake
- `S_ARADDR`  input  ADDR_W  read address
- `S_ARVALID` / `S_ARREADY`  input / output  1  AR handshake
- `S_RDATA`  output  32  read data
- `S_RRESP`  output  2  read response
- `S_RVALID` / `S_RREADY`  output / input  1  R handshake
- `trigger`  output  1  one-cycle start pulse to `dma`
- `length`  output  5  byte length to `dma`
- `source_address`  output  32  unaligned source address
- `destination_address`  output  32  unaligned destination address
- `done`  input  1  completion pulse from `dma`
- `irq`  output  1  level interrupt

## Operation
Register map (word offsets; low 2 address bits ignored):
- 0x00 CTRL: bit0 START (write-1, self-clearing, reads 0); bit1 IRQ_EN (R/W).
- 0x04 STATUS: bit0 BUSY (RO); bit1 DONE (sticky, write-1-to-clear).
- 0x08 SRC: 32-bit R/W. Each byte lane is written only if its WSTRB bit is set.
- 0x0C DST: 32-bit R/W, same per-lane WSTRB rule as SRC.
- 0x10 LEN: bits[4:0] R/W. Written only if WSTRB[0] is set. Upper bits read 0.
- Any other offset: write discarded, SLVERR; read returns 0, SLVERR.

Write path FSM, states W_IDLE → W_RESP:
- AW and W are captured independently, in either order or together.
- `S_AWREADY` = W_IDLE && !aw_held. `S_WREADY` = W_IDLE && !w_held.
- Once both are held, the register write executes on that edge and the FSM enters W_RESP with `S_BVALID`=1.
- W_RESP holds BVALID and BRESP until `S_BREADY`, then returns to W_IDLE and clears the held flags.

Read path FSM, states R_IDLE → R_DATA:
- `S_ARREADY` = R_IDLE.
- On AR handshake, RDATA/RRESP are registered and the FSM enters R_DATA with RVALID=1.
- Stays in R_DATA until `S_RREADY`, then returns to R_IDLE.
- The read and write FSMs are fully independent.

Control rules:
- START=1 with BUSY=0 and LEN≠0: `trigger` pulses, BUSY sets, OKAY.
- START=1 with BUSY=1 or LEN=0: no trigger, SLVERR. IRQ_EN is still updated from the same write.
- Writes to SRC, DST or LEN while BUSY=1 are discarded with SLVERR. This keeps the `dma` inputs stable for the whole transfer.
- `done`=1 while BUSY=1: BUSY clears and DONE sets on the same edge.
- `done`=1 while BUSY=0: ignored.
- A `done` arriving in the same cycle as a DONE W1C write: set wins, DONE stays 1.
- `irq` = registered DONE & IRQ_EN.
- `length`, `source_address` and `destination_address` are driven directly from their registers.

## Timing
- Reset (`rst`=0): all registers, flags and outputs are 0, except the READY outputs. `S_AWREADY`, `S_WREADY` and `S_ARREADY` read 1 because they decode idle state.
- Write latency: `S_BVALID` rises the cycle after the later of the AW/W handshakes.
- `trigger` is high for exactly that same first BVALID cycle. BUSY reads 1 from that cycle.
- Read latency: `S_RVALID` rises the cycle after the AR handshake. Data is sampled at the handshake edge.
- Back-to-back: a new AW/W is accepted no earlier than the cycle after the B handshake. A new AR is accepted no earlier than the cycle after the R handshake.
- BVALID, BRESP, RVALID, RDATA and RRESP stay stable while stalled on READY.
- `irq` goes high the cycle after `done` when IRQ_EN=1. It goes low the cycle after DONE is cleared.
- Reset asserted mid-transfer: BUSY, DONE and all registers clear immediately. Any pending B or R response is dropped.

## Test plan
- Program SRC=0x0000_1003, DST=0x0000_2001, LEN=7, then CTRL=0x3 -> all four writes return OKAY; `trigger` is one cycle wide in the BVALID cycle; outputs hold 0x1003/0x2001/7; STATUS reads 0x1.
- Drive `done` for 1 cycle -> STATUS reads 0x2 and `irq`=1 on the next cycle. Write STATUS=0x2 -> STATUS reads 0 and `irq` drops.
- While BUSY: write SRC=0xFFFF_FFFF and START -> both return SLVERR; SRC unchanged; no `trigger`.
- LEN=0 with START -> SLVERR, no `trigger`, BUSY stays 0.
- Present W three cycles before AW, hold BREADY low for 4 cycles, and write SRC with WSTRB=4'b0101 -> single write; BVALID held 4 cycles; only bytes 0 and 2 updated.
- Read 0x14, and assert `rst` low mid-BUSY -> read gives RDATA=0 with SLVERR; after reset all registers read 0 and `irq`=0.
